// File: rtl/mac8_pkg.sv
// Shared types and sizes for the MAC8 nibble sequencer.
// Optional early exit: MAC8_EARLY_EXIT_EN.
package mac8_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ADD,
    DONE
  } state_t;

  localparam int ACC_W   = 16;
  localparam int NIB_W   = 4;
  localparam int NIB_CNT = 4;
  localparam int MPL_W   = 8;

endpackage

// File: rtl/reversible_4bit_adder.sv
// Shared 4-bit adder slice used once per nibble step.
// Plain ripple sum; carry-in comes from a registered carry.
module reversible_4bit_adder
  import mac8_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             Cin,
  output logic [NIB_W-1:0] Sum,
  output logic             Carry
);

  logic [NIB_W:0] w_full;

  assign w_full = {1'b0, A}
                + {1'b0, B}
                + {{NIB_W{1'b0}}, Cin};

  assign Sum   = w_full[NIB_W-1:0];
  assign Carry = w_full[NIB_W];

endmodule

// File: rtl/mac8_nibble_sequencer.sv
// 8x8 shift-add MAC on one shared 4-bit adder, one nibble per cycle.
// Define MAC8_EARLY_EXIT_EN to stop scanning once the multiplier is empty.
module mac8_nibble_sequencer #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             clr_acc,
  output logic [ACC_W-1:0] acc,
  output logic             out_valid,
  output logic             ovf,
  output logic             busy
);
  import mac8_pkg::*;

  state_t             r_state;
  logic [ACC_W-1:0]   r_mcand;
  logic [MPL_W-1:0]   r_mplier;
  logic [2:0]         r_i;
  logic [1:0]         r_nib;
  logic               r_cy;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic               r_out_valid;
  logic               r_in_ready;

  logic [3:0]         w_base;
  logic [NIB_W-1:0]   w_acc_nib;
  logic [NIB_W-1:0]   w_mc_nib;
  logic [NIB_W-1:0]   w_sum;
  logic               w_carry;

  assign w_base    = {r_nib, 2'b00};
  assign w_acc_nib = r_acc[w_base +: NIB_W];
  assign w_mc_nib  = r_mcand[w_base +: NIB_W];

  reversible_4bit_adder u_add (
    .A     (w_acc_nib),
    .B     (w_mc_nib),
    .Cin   (r_cy),
    .Sum   (w_sum),
    .Carry (w_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_i         <= '0;
      r_nib       <= '0;
      r_cy        <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (clr_acc) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
          if (in_valid) begin
            r_mcand    <= {{(ACC_W-8){1'b0}}, a};
            r_mplier   <= b;
            r_i        <= '0;
            r_state    <= SCAN;
            r_in_ready <= 1'b0;
          end
        end
        SCAN: begin
`ifdef MAC8_EARLY_EXIT_EN
          if (r_mplier == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else
`endif
          if (r_mplier[0]) begin
            r_state <= ADD;
            r_nib   <= '0;
            r_cy    <= 1'b0;
          end else begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_i      <= r_i + 3'd1;
            if (r_i == 3'd7) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        ADD: begin
          r_acc[w_base +: NIB_W] <= w_sum;
          r_cy  <= w_carry;
          r_nib <= r_nib + 2'd1;
          // top-nibble carry wraps acc and only sets the sticky flag
          if (r_nib == 2'd3) begin
            r_ovf    <= r_ovf | w_carry;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_i      <= r_i + 3'd1;
            if (r_i == 3'd7) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= SCAN;
            end
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign acc       = r_acc;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign busy      = !r_in_ready;

endmodule

// File: tb/tb_mac8_nibble_sequencer.sv
// Directed bench for mac8_nibble_sequencer: results, latency, ovf, reset.
// Latency expectations follow MAC8_EARLY_EXIT_EN when defined.
module tb_mac8_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        clr_acc = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        in_ready;
  logic [15:0] acc;
  logic        out_valid;
  logic        ovf;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;

  mac8_nibble_sequencer #(.ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .clr_acc   (clr_acc),
    .acc       (acc),
    .out_valid (out_valid),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] bv);
    int pop;
    int h;
    pop = 0;
    h = 0;
    for (int k = 0; k < 8; k++) begin
      if (bv[k]) begin
        pop++;
        h = k + 1;
      end
    end
`ifdef MAC8_EARLY_EXIT_EN
    return 1 + ((h + 1 > 8) ? 8 : h + 1) + 4 * pop;
`else
    return 9 + 4 * pop + 0 * h;
`endif
  endfunction

  // called #1 after a posedge; accept happens at the next edge
  task automatic start(input logic [7:0] av,
                       input logic [7:0] bv,
                       input logic clr);
    in_valid = 1'b1;
    a = av;
    b = bv;
    clr_acc = clr;
    @(posedge clk);
    #1;
    t0 = cyc;
    in_valid = 1'b0;
    clr_acc = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat_exp);
    int lat;
    lat = -1;
    for (int k = 0; k < 80; k++) begin
      if (out_valid) begin
        lat = cyc - t0 + 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, " lat"}, lat, lat_exp);
    @(posedge clk);
    #1;
    chk({tag, " pulse"}, {31'b0, out_valid}, 0);
    chk({tag, " rdy"}, {31'b0, in_ready}, 1);
  endtask

  initial begin
    int pulses;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst acc", {16'b0, acc}, 0);
    chk("rst ovf", {31'b0, ovf}, 0);
    chk("rst ov", {31'b0, out_valid}, 0);
    chk("rst rdy", {31'b0, in_ready}, 1);
    chk("rst busy", {31'b0, busy}, 0);
    @(posedge clk);
    #1;

    start(8'd3, 8'd5, 1'b1);
    chk("3x5 busy", {31'b0, busy}, 1);
    wait_done("3x5", exp_lat(8'd5));
    chk("3x5 acc", {16'b0, acc}, 15);

    start(8'd10, 8'd10, 1'b0);
    wait_done("10x10", exp_lat(8'd10));
    chk("10x10 acc", {16'b0, acc}, 115);
    chk("10x10 ovf", {31'b0, ovf}, 0);

    start(8'd255, 8'd255, 1'b1);
    wait_done("ff1", exp_lat(8'd255));
    chk("ff1 acc", {16'b0, acc}, 65025);
    chk("ff1 ovf", {31'b0, ovf}, 0);

    start(8'd255, 8'd255, 1'b0);
    wait_done("ff2", exp_lat(8'd255));
    chk("ff2 acc", {16'b0, acc}, 64514);
    chk("ff2 ovf", {31'b0, ovf}, 1);

    start(8'd0, 8'd0, 1'b0);
    wait_done("zero", exp_lat(8'd0));
    chk("zero acc", {16'b0, acc}, 64514);
    chk("ovf sticky", {31'b0, ovf}, 1);

    start(8'd2, 8'd3, 1'b1);
    wait_done("clr", exp_lat(8'd3));
    chk("clr acc", {16'b0, acc}, 6);
    chk("clr ovf", {31'b0, ovf}, 0);

    start(8'd7, 8'd9, 1'b0);
    in_valid = 1'b1;
    a = 8'd1;
    b = 8'd1;
    chk("busy rdy", {31'b0, in_ready}, 0);
    chk("busy busy", {31'b0, busy}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    wait_done("busy", exp_lat(8'd9));
    chk("busy acc", {16'b0, acc}, 69);
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    chk("busy extra ov", pulses, 0);

    // b=1: cycles T+2..T+5 are nibbles 0..3, so T+4 is nibble 2
    start(8'd5, 8'd1, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("mid rst acc", {16'b0, acc}, 0);
    chk("mid rst busy", {31'b0, busy}, 0);
    chk("mid rst rdy", {31'b0, in_ready}, 1);
    chk("mid rst ovf", {31'b0, ovf}, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    chk("mid rst no ov", pulses, 0);

    start(8'd4, 8'd4, 1'b0);
    wait_done("post", exp_lat(8'd4));
    chk("post acc", {16'b0, acc}, 16);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
